// File: rtl/mmio_bus_arbiter_if.sv
// Signal bundle between the two MMIO requesters, the arbiter and the FPro MMIO controller.
// The arbiter connects through the slave modport; requesters and the bus model use master.
interface mmio_bus_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wr_data;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rd_data;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wr_data;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rd_data;

  logic              mmio_cs;
  logic              mmio_wr;
  logic              mmio_rd;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wr_data;
  logic [DATA_W-1:0] mmio_rd_data;

  logic [1:0]        grant;

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wr_data,
    input  m0_ack, m0_rd_data,
    output m1_req, m1_wr, m1_addr, m1_wr_data,
    input  m1_ack, m1_rd_data,
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data,
    input  grant
  );

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wr_data,
    output m0_ack, m0_rd_data,
    input  m1_req, m1_wr, m1_addr, m1_wr_data,
    output m1_ack, m1_rd_data,
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data,
    output grant
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Two-requester arbiter for the FPro MMIO bus: one single-cycle strobe per
// transaction, read data captured on the strobe and returned with a one-cycle ack.
//
// state | meaning
// IDLE  | no transaction; arbitrate and register the winner's request onto the bus
// ISSUE | strobe on the bus; read data sampled at the closing edge
// RESP  | ack pulse to the winner; requests ignored
module mmio_bus_arbiter #(
  parameter int ADDR_W    = 21,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  mmio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        grant_q, grant_d;

  logic any_req;
  logic winner;

  // winner: 0 = m0, 1 = m1; last_grant uses the same encoding
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    winner  = 1'b0;
    if (PRIO_MODE != 0) begin
      winner = ~bus.m0_req;
    end else if (bus.m0_req && bus.m1_req) begin
      winner = ~last_grant_q;
    end else begin
      winner = bus.m1_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cs_d         = cs_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    grant_d      = grant_q;

    unique case (state_q)
      IDLE: begin
        cs_d   = 1'b0;
        wr_d   = 1'b0;
        rd_d   = 1'b0;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        if (!any_req) begin
          addr_d  = '0;
          wdata_d = '0;
          grant_d = 2'b00;
        end else begin
          addr_d       = winner ? bus.m1_addr    : bus.m0_addr;
          wdata_d      = winner ? bus.m1_wr_data : bus.m0_wr_data;
          wr_d         = winner ? bus.m1_wr      : bus.m0_wr;
          rd_d         = winner ? ~bus.m1_wr     : ~bus.m0_wr;
          cs_d         = 1'b1;
          grant_d      = winner ? 2'b10 : 2'b01;
          last_grant_d = winner;
          owner_d      = winner;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        // the controller answers combinationally while the strobe is up
        if (rd_q) begin
          if (owner_q) rdata1_d = bus.mmio_rd_data;
          else         rdata0_d = bus.mmio_rd_data;
        end
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
        state_d = RESP;
      end

      RESP: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant_d = 2'b00;
        state_d = IDLE;
      end

      default: begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to m1 so that m0 takes the first contention
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      grant_q      <= grant_d;
    end
  end

  assign bus.mmio_cs      = cs_q;
  assign bus.mmio_wr      = wr_q;
  assign bus.mmio_rd      = rd_q;
  assign bus.mmio_addr    = addr_q;
  assign bus.mmio_wr_data = wdata_q;
  assign bus.m0_ack       = ack0_q;
  assign bus.m1_ack       = ack1_q;
  assign bus.m0_rd_data   = rdata0_q;
  assign bus.m1_rd_data   = rdata1_q;
  assign bus.grant        = grant_q;

  assert property (@(posedge clk) disable iff (!reset) !(bus.mmio_rd && bus.mmio_wr));
  assert property (@(posedge clk) disable iff (!reset) !(bus.m0_ack && bus.m1_ack));
  assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.grant));

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: a round-robin and a fixed-priority instance, directed
// stimulus pushing expected transactions, and a negedge monitor comparing them.
module tb_mmio_bus_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;

  typedef struct {
    bit            master;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            scyc;
    bit            no_ack;
  } txn_t;

  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mmio_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a));
  mmio_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b));

  // bus model: fixed read values for the addresses the directed tests use
  function automatic logic [DW-1:0] rd_value(input logic [AW-1:0] a);
    case (a)
      21'h000C40: return 32'hDEADBEEF;
      21'h000100: return 32'h11111111;
      21'h000200: return 32'h22222222;
      default:    return {11'h5A5, a};
    endcase
  endfunction

  assign bus_a.mmio_rd_data = bus_a.mmio_rd ? rd_value(bus_a.mmio_addr) : '0;
  assign bus_b.mmio_rd_data = bus_b.mmio_rd ? rd_value(bus_b.mmio_addr) : '0;

  logic          cs_m[2], wr_m[2], rd_m[2], ack0_m[2], ack1_m[2], rst_q[2];
  logic [1:0]    grant_m[2];
  logic [AW-1:0] addr_m[2];
  logic [DW-1:0] wd_m[2], rd0_m[2], rd1_m[2];

  always_comb begin
    cs_m[0] = bus_a.mmio_cs;     cs_m[1] = bus_b.mmio_cs;
    wr_m[0] = bus_a.mmio_wr;     wr_m[1] = bus_b.mmio_wr;
    rd_m[0] = bus_a.mmio_rd;     rd_m[1] = bus_b.mmio_rd;
    ack0_m[0] = bus_a.m0_ack;    ack0_m[1] = bus_b.m0_ack;
    ack1_m[0] = bus_a.m1_ack;    ack1_m[1] = bus_b.m1_ack;
    grant_m[0] = bus_a.grant;    grant_m[1] = bus_b.grant;
    addr_m[0] = bus_a.mmio_addr; addr_m[1] = bus_b.mmio_addr;
    wd_m[0] = bus_a.mmio_wr_data; wd_m[1] = bus_b.mmio_wr_data;
    rd0_m[0] = bus_a.m0_rd_data; rd0_m[1] = bus_b.m0_rd_data;
    rd1_m[0] = bus_a.m1_rd_data; rd1_m[1] = bus_b.m1_rd_data;
  end

  always @(posedge clk) begin
    rst_q[0] <= reset_a;
    rst_q[1] <= reset_b;
  end

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  txn_t          sb_q[2][$];
  txn_t          pend[2];
  bit            pend_v[2];
  int            pend_cyc[2];
  logic [DW-1:0] shadow[2][2];
  txn_t          mon_e;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_q[d] !== 1'b1) begin
        pend_v[d]    = 1'b0;
        shadow[d][0] = '0;
        shadow[d][1] = '0;
      end
      if (cs_m[d]) begin
        check("strobe_no_ack", d, {ack1_m[d], ack0_m[d]}, 2'b00);
        if (sb_q[d].size() == 0) begin
          check("unexpected_strobe", d, 1, 0);
        end else begin
          mon_e = sb_q[d].pop_front();
          check("strobe_cycle", d, cyc, mon_e.scyc);
          check("strobe_grant", d, grant_m[d], mon_e.master ? 2'b10 : 2'b01);
          check("strobe_wr_rd", d, {wr_m[d], rd_m[d]}, {mon_e.wr, ~mon_e.wr});
          check("strobe_addr", d, addr_m[d], mon_e.addr);
          check("strobe_wr_data", d, wd_m[d], mon_e.wdata);
          check("strobe_m0_rd_data", d, rd0_m[d], shadow[d][0]);
          check("strobe_m1_rd_data", d, rd1_m[d], shadow[d][1]);
          pend[d]     = mon_e;
          pend_v[d]   = 1'b1;
          pend_cyc[d] = cyc;
        end
      end else if (ack0_m[d] || ack1_m[d]) begin
        if (!pend_v[d] || pend[d].no_ack) begin
          check("unexpected_ack", d, {ack1_m[d], ack0_m[d]}, 2'b00);
        end else begin
          check("ack_select", d, {ack1_m[d], ack0_m[d]}, pend[d].master ? 2'b10 : 2'b01);
          check("ack_latency", d, cyc - pend_cyc[d], 1);
          check("resp_grant", d, grant_m[d], pend[d].master ? 2'b10 : 2'b01);
          if (!pend[d].wr) shadow[d][pend[d].master] = pend[d].rdata;
          check("ack_m0_rd_data", d, rd0_m[d], shadow[d][0]);
          check("ack_m1_rd_data", d, rd1_m[d], shadow[d][1]);
        end
        pend_v[d] = 1'b0;
      end else if (rst_q[d] === 1'b1) begin
        check("idle_grant", d, grant_m[d], 2'b00);
      end
    end
  end

  task automatic drive_req(input int d, input bit m, input bit v, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (d == 0 && !m) begin
      bus_a.m0_req = v; bus_a.m0_wr = wr; bus_a.m0_addr = a; bus_a.m0_wr_data = w;
    end else if (d == 0) begin
      bus_a.m1_req = v; bus_a.m1_wr = wr; bus_a.m1_addr = a; bus_a.m1_wr_data = w;
    end else if (!m) begin
      bus_b.m0_req = v; bus_b.m0_wr = wr; bus_b.m0_addr = a; bus_b.m0_wr_data = w;
    end else begin
      bus_b.m1_req = v; bus_b.m1_wr = wr; bus_b.m1_addr = a; bus_b.m1_wr_data = w;
    end
  endtask

  task automatic push(input int d, input bit m, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] w, input int scyc, input bit no_ack);
    txn_t e;
    e.master = m;
    e.wr     = wr;
    e.addr   = a;
    e.wdata  = w;
    e.rdata  = wr ? '0 : rd_value(a);
    e.scyc   = scyc;
    e.no_ack = no_ack;
    sb_q[d].push_back(e);
  endtask

  task automatic wait_ack(input int d, input bit m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m ? ack1_m[d] : ack0_m[d]) begin
        ok = 1'b1;
        return;
      end
    end
    check(m ? "ack_timeout_m1" : "ack_timeout_m0", d, 0, 1);
  endtask

  // requester: raise req, keep it up through n acks, drop it in the cycle after the last
  task automatic hold(input int d, input bit m, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] w, input int n);
    bit ok;
    drive_req(d, m, 1'b1, wr, a, w);
    for (int i = 0; i < n; i++) begin
      wait_ack(d, m, ok);
      if (!ok) break;
    end
    @(posedge clk); #1;
    drive_req(d, m, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic single(input int d, input bit m, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] w);
    @(posedge clk); #1;
    push(d, m, wr, a, w, cyc + 1, 1'b0);
    hold(d, m, wr, a, w, 1);
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_cs_wr_rd", d, {cs_m[d], wr_m[d], rd_m[d]}, 3'b000);
    check("rst_addr", d, addr_m[d], 0);
    check("rst_wr_data", d, wd_m[d], 0);
    check("rst_acks", d, {ack1_m[d], ack0_m[d]}, 2'b00);
    check("rst_m0_rd_data", d, rd0_m[d], 0);
    check("rst_m1_rd_data", d, rd1_m[d], 0);
    check("rst_grant", d, grant_m[d], 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      drive_req(d, 1'b0, 1'b0, 1'b0, '0, '0);
      drive_req(d, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk); #1;
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (2) @(posedge clk);

    // single read and single write on the round-robin instance
    single(0, 1'b0, 1'b0, 21'h000C40, 32'h0);
    single(0, 1'b1, 1'b1, 21'h000080, 32'h000000A5);

    // contention: last grant is m1, so order is m0, m1, m0, m1 three cycles apart
    @(posedge clk); #1;
    c = cyc;
    push(0, 1'b0, 1'b1, 21'h000010, 32'h12345678, c + 1,  1'b0);
    push(0, 1'b1, 1'b0, 21'h000020, 32'h0,        c + 4,  1'b0);
    push(0, 1'b0, 1'b1, 21'h000010, 32'h12345678, c + 7,  1'b0);
    push(0, 1'b1, 1'b0, 21'h000020, 32'h0,        c + 10, 1'b0);
    fork
      hold(0, 1'b0, 1'b1, 21'h000010, 32'h12345678, 2);
      hold(0, 1'b1, 1'b0, 21'h000020, 32'h0, 2);
    join

    // read data isolation
    single(0, 1'b0, 1'b0, 21'h000100, 32'h0);
    single(0, 1'b1, 1'b0, 21'h000200, 32'h0);
    @(negedge clk);
    check("isolation_m0_rd_data", 0, rd0_m[0], 32'h11111111);
    check("isolation_m1_rd_data", 0, rd1_m[0], 32'h22222222);

    // reset during ISSUE: strobe seen, no ack, outputs cleared
    @(posedge clk); #1;
    push(0, 1'b1, 1'b0, 21'h000300, 32'h0, cyc + 1, 1'b1);
    drive_req(0, 1'b1, 1'b1, 1'b0, 21'h000300, 32'h0);
    @(posedge clk); #1;
    reset_a = 1'b0;
    drive_req(0, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk); #1;
    reset_a = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    push(0, 1'b0, 1'b0, 21'h000100, 32'h0,        c + 1, 1'b0);
    push(0, 1'b1, 1'b1, 21'h000040, 32'h0000CAFE, c + 4, 1'b0);
    fork
      hold(0, 1'b0, 1'b0, 21'h000100, 32'h0, 1);
      hold(0, 1'b1, 1'b1, 21'h000040, 32'h0000CAFE, 1);
    join

    // fixed priority: m0 keeps winning, m1 served once m0 drops
    @(posedge clk); #1;
    c = cyc;
    push(1, 1'b0, 1'b0, 21'h000C40, 32'h0,        c + 1,  1'b0);
    push(1, 1'b0, 1'b0, 21'h000C40, 32'h0,        c + 4,  1'b0);
    push(1, 1'b0, 1'b0, 21'h000C40, 32'h0,        c + 7,  1'b0);
    push(1, 1'b1, 1'b1, 21'h000080, 32'h000000A5, c + 10, 1'b0);
    fork
      hold(1, 1'b0, 1'b0, 21'h000C40, 32'h0, 3);
      hold(1, 1'b1, 1'b1, 21'h000080, 32'h000000A5, 1);
    join

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 0, sb_q[0].size(), 0);
    check("sb_drained", 1, sb_q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
